// File: rtl/px_osc_counter_array.sv
// Pixel-oscillator frequency counter: enables masked oscillators, counts synchronised
// rising edges of each channel over a gate window, and latches results for readout.
module px_osc_counter_array #(
    parameter int NUM_PX     = 16,
    parameter int CNT_W      = 16,
    parameter int GATE_W     = 20,
    parameter int SETTLE_CYC = 64,
    parameter int ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_PX-1:0] clk_px,
    input  logic              start,
    input  logic              abort,
    input  logic              cont,
    input  logic [NUM_PX-1:0] ch_mask,
    input  logic [GATE_W-1:0] gate_len,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [NUM_PX-1:0] osc_en,
    output logic              busy,
    output logic              drdy,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_PX-1:0] ovf,
    output logic [7:0]        win_cnt
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_COUNT,
        S_LATCH
    } state_t;

    state_t state, state_nxt;

    logic [NUM_PX-1:0] sync0, sync1, sync2, px_edge;
    logic              accept;
    logic [NUM_PX-1:0] mask_q;
    logic [GATE_W-1:0] gate_len_q, gate_cnt;
    logic              cont_q;
    logic [SET_W-1:0]  set_cnt;
    logic [CNT_W-1:0]  live [NUM_PX];
    logic [NUM_PX-1:0] live_ovf;
    logic [CNT_W-1:0]  res  [NUM_PX];
    logic [CNT_W-1:0]  rd_mux;

    assign px_edge = sync1 & ~sync2;
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0 <= '0;
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync0 <= clk_px;
            sync1 <= sync0;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort && (gate_len != '0)) begin
                    accept    = 1'b1;
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort)               state_nxt = S_IDLE;
                else if (set_cnt == '0)  state_nxt = S_COUNT;
            end
            S_COUNT: begin
                if (abort)                           state_nxt = S_IDLE;
                else if (gate_cnt == GATE_W'(1))     state_nxt = S_LATCH;
            end
            S_LATCH: begin
                // latch always completes; abort only blocks the continuous restart
                if (cont_q && cont && !abort) state_nxt = S_COUNT;
                else                          state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q     <= '0;
            gate_len_q <= '0;
            cont_q     <= 1'b0;
            set_cnt    <= '0;
            gate_cnt   <= '0;
            osc_en     <= '0;
        end else begin
            if (accept) begin
                mask_q     <= ch_mask;
                gate_len_q <= gate_len;
                cont_q     <= cont;
                set_cnt    <= SET_W'(SETTLE_CYC - 1);
            end else if (state == S_SETTLE && set_cnt != '0) begin
                set_cnt <= set_cnt - SET_W'(1);
            end
            // reload outside COUNT so every window (incl. continuous restarts) starts full
            if (state == S_COUNT) gate_cnt <= gate_cnt - GATE_W'(1);
            else                  gate_cnt <= gate_len_q;
            if (state_nxt == S_IDLE) osc_en <= '0;
            else if (accept)         osc_en <= ch_mask;
            else                     osc_en <= mask_q;
        end
    end

    // live counters only exist inside COUNT; any other state drops them
    always_ff @(posedge clk) begin
        if (rst) begin
            live_ovf <= '0;
            for (int unsigned i = 0; i < NUM_PX; i++) live[i] <= '0;
        end else if (state != S_COUNT) begin
            live_ovf <= '0;
            for (int unsigned i = 0; i < NUM_PX; i++) live[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_PX; i++) begin
                if (mask_q[i] && px_edge[i]) begin
                    if (live[i] == '1) live_ovf[i] <= 1'b1;
                    else               live[i]     <= live[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf     <= '0;
            drdy    <= 1'b0;
            win_cnt <= '0;
            for (int unsigned i = 0; i < NUM_PX; i++) res[i] <= '0;
        end else if (state == S_LATCH) begin
            ovf     <= live_ovf;
            drdy    <= 1'b1;
            win_cnt <= win_cnt + 8'd1;
            for (int unsigned i = 0; i < NUM_PX; i++) res[i] <= live[i];
        end else if (accept) begin
            drdy <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NUM_PX; i++) begin
            if (rd_addr == ADDR_W'(i)) rd_mux = res[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rd_data <= '0;
        else     rd_data <= rd_mux;
    end

endmodule

// File: tb/tb_px_osc_counter_array.sv
// Directed bench for px_osc_counter_array: table-driven single-shot windows on a 16-bit
// and an 8-bit counter build, plus hand-written continuous/abort/reset sequences.
module tb_px_osc_counter_array;

    localparam int NPX = 16;
    localparam int SET = 64;

    logic           clk = 1'b0;
    logic           rst, start, abort, cont;
    logic [NPX-1:0] clk_px = '0;
    logic [NPX-1:0] ch_mask;
    logic [19:0]    gate_len;
    logic [3:0]     rd_addr;

    logic [NPX-1:0] osc_en, ovf, osc_en8, ovf8;
    logic           busy, drdy, busy8, drdy8;
    logic [15:0]    rd_data;
    logic [7:0]     rd_data8, win_cnt, win_cnt8;

    px_osc_counter_array #(.NUM_PX(NPX), .CNT_W(16), .GATE_W(20), .SETTLE_CYC(SET), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .clk_px(clk_px), .start(start), .abort(abort), .cont(cont),
        .ch_mask(ch_mask), .gate_len(gate_len), .rd_addr(rd_addr), .osc_en(osc_en),
        .busy(busy), .drdy(drdy), .rd_data(rd_data), .ovf(ovf), .win_cnt(win_cnt)
    );

    px_osc_counter_array #(.NUM_PX(NPX), .CNT_W(8), .GATE_W(20), .SETTLE_CYC(SET), .ADDR_W(4)) dut8 (
        .clk(clk), .rst(rst), .clk_px(clk_px), .start(start), .abort(abort), .cont(cont),
        .ch_mask(ch_mask), .gate_len(gate_len), .rd_addr(rd_addr), .osc_en(osc_en8),
        .busy(busy8), .drdy(drdy8), .rd_data(rd_data8), .ovf(ovf8), .win_cnt(win_cnt8)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int px_per  = 0;
    int cyc     = 0;

    // pixel oscillators: period px_per clk cycles, per-channel phase offset
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NPX; i++)
                clk_px[i] = (px_per != 0) && (((cyc + i) % px_per) < (px_per / 2));
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] mask;
        int          gate;
        int          per;
        int          exp16;
        int          exp8;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input longint act, input longint lo, input longint hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            if (lo == hi) $display("FAIL %s: got %0d, expected %0d", name, act, lo);
            else          $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0, 0);
    endtask

    task automatic wait_win(input logic [7:0] target, output int n);
        n = 0;
        while (win_cnt != target && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (win_cnt != target) chk("win_timeout", 1, 0, 0);
    endtask

    task automatic read_ch(input int ch, output logic [15:0] d16, output logic [7:0] d8);
        @(negedge clk); rd_addr = 4'(ch);
        @(posedge clk); #1;
        d16 = rd_data;
        d8  = rd_data8;
    endtask

    task automatic run_shot(input vec_t v, input int idx);
        logic [7:0]  w0;
        logic [15:0] d16;
        logic [7:0]  d8;
        int          n, e16, e8;
        px_per = v.per;
        @(negedge clk);
        ch_mask = v.mask; gate_len = 20'(v.gate); cont = 1'b0; start = 1'b1;
        w0 = win_cnt;
        @(posedge clk); #1;
        chk($sformatf("v%0d_busy", idx), busy, 1, 1);
        chk($sformatf("v%0d_osc_en", idx), osc_en, v.mask, v.mask);
        @(negedge clk); start = 1'b0;
        wait_idle(n);
        chk($sformatf("v%0d_latency", idx), n, SET + v.gate + 1, SET + v.gate + 1);
        chk($sformatf("v%0d_drdy", idx), drdy, 1, 1);
        chk($sformatf("v%0d_win_cnt", idx), win_cnt, 8'(w0 + 8'd1), 8'(w0 + 8'd1));
        chk($sformatf("v%0d_osc_off", idx), osc_en, 0, 0);
        chk($sformatf("v%0d_ovf16", idx), ovf, 0, 0);
        chk($sformatf("v%0d_ovf8", idx), ovf8, (v.exp8 == 255) ? v.mask : 16'h0, (v.exp8 == 255) ? v.mask : 16'h0);
        for (int ch = 0; ch < NPX; ch++) begin
            read_ch(ch, d16, d8);
            e16 = v.mask[ch] ? v.exp16 : 0;
            e8  = v.mask[ch] ? v.exp8  : 0;
            chk($sformatf("v%0d_rd16_ch%0d", idx, ch), d16, (e16 > 0) ? e16 - 1 : 0, (e16 > 0) ? e16 + 1 : 1);
            if (e8 == 255) chk($sformatf("v%0d_rd8_ch%0d", idx, ch), d8, 255, 255);
            else           chk($sformatf("v%0d_rd8_ch%0d", idx, ch), d8, (e8 > 0) ? e8 - 1 : 0, (e8 > 0) ? e8 + 1 : 1);
        end
    endtask

    initial begin
        logic [7:0]  w0;
        logic [15:0] d16;
        logic [7:0]  d8;
        int          n;

        vecs[0] = '{mask: 16'h0001, gate: 1000, per: 10, exp16: 100,  exp8: 100};
        vecs[1] = '{mask: 16'h00F0, gate: 200,  per: 8,  exp16: 25,   exp8: 25};
        vecs[2] = '{mask: 16'hFFFF, gate: 1,    per: 2,  exp16: 0,    exp8: 0};
        vecs[3] = '{mask: 16'h8001, gate: 4000, per: 4,  exp16: 1000, exp8: 255};

        rst = 1'b1; start = 1'b0; abort = 1'b0; cont = 1'b0;
        ch_mask = '0; gate_len = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0, 0);
        chk("rst_drdy", drdy, 0, 0);
        chk("rst_win_cnt", win_cnt, 0, 0);
        chk("rst_osc_en", osc_en, 0, 0);
        chk("rst_ovf", ovf, 0, 0);
        chk("rst_rd_data", rd_data, 0, 0);
        @(negedge clk); rst = 1'b0;

        for (int v = 0; v < 4; v++) run_shot(vecs[v], v);

        // continuous windows, then drop cont mid-window
        px_per = 10;
        @(negedge clk); ch_mask = 16'h0001; gate_len = 20'd100; cont = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        w0 = win_cnt;
        @(negedge clk); start = 1'b0;
        wait_win(8'(w0 + 8'd1), n);
        chk("cont_first_window", n, SET + 101, SET + 101);
        chk("cont_drdy", drdy, 1, 1);
        chk("cont_busy", busy, 1, 1);
        chk("cont_osc_on", osc_en, 16'h0001, 16'h0001);
        wait_win(8'(w0 + 8'd2), n);
        chk("cont_second_window", n, 101, 101);
        wait_win(8'(w0 + 8'd3), n);
        chk("cont_third_window", n, 101, 101);
        @(negedge clk); cont = 1'b0;
        wait_idle(n);
        chk("cont_stop_latency", n, 101, 101);
        chk("cont_stop_win_cnt", win_cnt, 8'(w0 + 8'd4), 8'(w0 + 8'd4));
        chk("cont_stop_osc_off", osc_en, 0, 0);
        read_ch(0, d16, d8);
        chk("cont_rd_ch0", d16, 9, 11);

        // abort during COUNT keeps prior result
        run_shot(vecs[0], 4);
        @(negedge clk); rd_addr = 4'd0; ch_mask = 16'h0001; gate_len = 20'd1000; start = 1'b1;
        @(posedge clk); #1;
        w0 = win_cnt;
        @(negedge clk); start = 1'b0;
        repeat (200) @(posedge clk);
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", busy, 0, 0);
        chk("abort_osc_off", osc_en, 0, 0);
        chk("abort_drdy", drdy, 0, 0);
        chk("abort_win_cnt", win_cnt, w0, w0);
        @(negedge clk); abort = 1'b0;
        @(posedge clk); #1;
        chk("abort_rd_data", rd_data, 99, 101);

        // abort in the LATCH cycle: latch completes
        @(negedge clk); ch_mask = 16'h0001; gate_len = 20'd50; start = 1'b1;
        @(posedge clk); #1;
        w0 = win_cnt;
        @(negedge clk); start = 1'b0;
        repeat (SET + 50) @(posedge clk);
        #1;
        chk("latch_abort_in_latch", busy, 1, 1);
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1;
        chk("latch_abort_busy", busy, 0, 0);
        chk("latch_abort_drdy", drdy, 1, 1);
        chk("latch_abort_win_cnt", win_cnt, 8'(w0 + 8'd1), 8'(w0 + 8'd1));
        @(negedge clk); abort = 1'b0;
        @(posedge clk); #1;
        chk("latch_abort_rd_data", rd_data, 4, 6);

        // ignored starts
        @(negedge clk); ch_mask = 16'hFFFF; gate_len = 20'd0; start = 1'b1;
        @(posedge clk); #1;
        chk("gate0_busy", busy, 0, 0);
        chk("gate0_osc_en", osc_en, 0, 0);
        chk("gate0_drdy", drdy, 1, 1);
        @(negedge clk); gate_len = 20'd10; abort = 1'b1;
        @(posedge clk); #1;
        chk("start_abort_busy", busy, 0, 0);
        chk("start_abort_drdy", drdy, 1, 1);
        @(negedge clk); start = 1'b0; abort = 1'b0;

        // start while busy does not retrigger or change the mask
        @(negedge clk); ch_mask = 16'h0001; gate_len = 20'd300; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk); ch_mask = 16'hFFFF; gate_len = 20'd5; start = 1'b1;
        @(posedge clk); #1;
        chk("busy_start_osc_en", osc_en, 16'h0001, 16'h0001);
        chk("busy_start_busy", busy, 1, 1);
        @(negedge clk); start = 1'b0;
        wait_idle(n);
        chk("busy_start_latency", n + 101, SET + 301, SET + 301);
        read_ch(0, d16, d8);
        chk("busy_start_rd_ch0", d16, 29, 31);
        read_ch(1, d16, d8);
        chk("busy_start_rd_ch1", d16, 0, 0);

        // reset mid-COUNT
        @(negedge clk); ch_mask = 16'hFFFF; gate_len = 20'd300; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0; rd_addr = 4'd0;
        repeat (150) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", busy, 0, 0);
        chk("midrst_drdy", drdy, 0, 0);
        chk("midrst_win_cnt", win_cnt, 0, 0);
        chk("midrst_osc_en", osc_en, 0, 0);
        chk("midrst_ovf8", ovf8, 0, 0);
        chk("midrst_rd_data", rd_data, 0, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_rd_after", rd_data, 0, 0);
        chk("midrst_idle_after", busy, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
